pred_pmu_ctrl: RTL

//   Measurement-window controller for the branch/JAL prediction counter block.
//   - Clears the counters, gates their feedback-valid input for a programmed window,

---
 rtl/pred_pmu_pkg.sv | 27 ++
 rtl/pred_pmu_snap.sv | 44 ++++
 rtl/pred_pmu_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pred_pmu_pkg.sv
// Shared types and constants for the prediction-counter measurement controller.
package pred_pmu_pkg;

    localparam int unsigned DEF_WIN_W = 32;
    localparam int unsigned DEF_N_CNT = 4;
    localparam int unsigned DEF_CNT_W = 32;

    // Counter slots inside the packed cnt_in bus
    localparam int unsigned CNT_BR        = 0;
    localparam int unsigned CNT_BR_WRONG  = 1;
    localparam int unsigned CNT_JAL       = 2;
    localparam int unsigned CNT_JAL_WRONG = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DRAIN  = 3'd4
    } pmu_state_e;

    // Index width that stays legal for a single-counter build
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pred_pmu_snap.sv
// Snapshot register file with read pointer and read mux for the drain port.
module pred_pmu_snap
    import pred_pmu_pkg::*;
#(
    parameter  int unsigned N_CNT = DEF_N_CNT,
    parameter  int unsigned CNT_W = DEF_CNT_W,
    localparam int unsigned IDX_W = idx_width(N_CNT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   capture,
    input  logic                   advance,
    input  logic [N_CNT*CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0]       rd_data,
    output logic [IDX_W-1:0]       rd_idx,
    output logic                   rd_last
);

    logic [CNT_W-1:0] snap_q [N_CNT];

    // Capture every counter at once; hold until the next capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(N_CNT); k++) snap_q[k] <= '0;
        end else if (capture) begin
            for (int k = 0; k < int'(N_CNT); k++) snap_q[k] <= cnt_in[k*CNT_W +: CNT_W];
        end
    end

    // Read pointer: rewinds on capture, steps per handshake, wraps after the last word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_idx <= '0;
        end else if (capture) begin
            rd_idx <= '0;
        end else if (advance) begin
            rd_idx <= rd_last ? '0 : rd_idx + IDX_W'(1);
        end
    end

    assign rd_last = (rd_idx == IDX_W'(N_CNT - 1));
    assign rd_data = snap_q[rd_idx];

endmodule

// File: rtl/pred_pmu_ctrl.sv
// Measurement-window controller: clear counters, gate feedback for a window,
// snapshot, then drain one word per handshake.
// Optional macro PMU_IRQ_EN adds a sticky window-done interrupt.
module pred_pmu_ctrl
    import pred_pmu_pkg::*;
#(
    parameter  int unsigned WIN_W = DEF_WIN_W,
    parameter  int unsigned N_CNT = DEF_N_CNT,
    parameter  int unsigned CNT_W = DEF_CNT_W,
    localparam int unsigned IDX_W = idx_width(N_CNT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_start,
    input  logic                   cfg_stop,
    input  logic [WIN_W-1:0]       cfg_window,
    input  logic                   fb_valid_i,
    output logic                   fb_valid_o,
    output logic                   pmu_rst_n_o,
    input  logic [N_CNT*CNT_W-1:0] cnt_in,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [CNT_W-1:0]       rd_data,
    output logic [IDX_W-1:0]       rd_idx,
    output logic                   rd_last,
    output logic                   busy,
    output logic                   irq,
    input  logic                   irq_clr
);

    pmu_state_e       state_q, state_d;
    logic [WIN_W-1:0] win_len_q;
    logic [WIN_W-1:0] win_cnt_q;
    logic             win_expire;
    logic             gate_open;
    logic             in_clr;
    logic             capture;
    logic             rd_fire;
    logic             drain_done;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Window length is latched only when a start is accepted
    always_ff @(posedge clk) begin
        if (!rst_n)                              win_len_q <= '0;
        else if (state_q == ST_IDLE && cfg_start) win_len_q <= cfg_window;
    end

    // Cycle counter for the open window; wraps freely when the window is unbounded
    always_ff @(posedge clk) begin
        if (!rst_n)                  win_cnt_q <= '0;
        else if (state_q == ST_CLR)  win_cnt_q <= '0;
        else if (state_q == ST_RUN)  win_cnt_q <= win_cnt_q + WIN_W'(1);
    end

    assign win_expire = (win_len_q != '0) && (win_cnt_q == win_len_q - WIN_W'(1));
    assign rd_fire    = rd_valid & rd_ready;
    assign drain_done = rd_fire & rd_last;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cfg_start) state_d = ST_CLR;
            ST_CLR:    state_d = ST_RUN;
            ST_RUN:    if (cfg_stop || win_expire) state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State-decoded controls
    always_comb begin
        gate_open = 1'b0;
        in_clr    = 1'b0;
        capture   = 1'b0;
        rd_valid  = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE:   busy      = 1'b0;
            ST_CLR:    in_clr    = 1'b1;
            ST_RUN:    gate_open = 1'b1;
            ST_SETTLE: capture   = 1'b1;
            ST_DRAIN:  rd_valid  = 1'b1;
            default:   busy      = 1'b0;
        endcase
    end

    assign fb_valid_o  = fb_valid_i & gate_open;
    assign pmu_rst_n_o = rst_n & ~in_clr;

    pred_pmu_snap #(
        .N_CNT (N_CNT),
        .CNT_W (CNT_W)
    ) u_snap (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (capture),
        .advance (rd_fire),
        .cnt_in  (cnt_in),
        .rd_data (rd_data),
        .rd_idx  (rd_idx),
        .rd_last (rd_last)
    );

`ifdef PMU_IRQ_EN
    logic irq_q;

    // Sticky done flag; a new completion beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst_n)          irq_q <= 1'b0;
        else if (drain_done) irq_q <= 1'b1;
        else if (irq_clr)    irq_q <= 1'b0;
    end

    assign irq = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule
